// File: rtl/xs3_pkg.sv
// Shared types and constants for the binary-to-excess-3 encoder.
// The FSM encoding and per-digit constants live here so the top and the digit fixer agree.
package xs3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        BIAS  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] XS3_BIAS      = 4'd3;
    localparam logic [3:0] DABBLE_THRESH = 4'd5;
    localparam logic [3:0] XS3_ZERO      = 4'b0011;

endpackage

// File: rtl/bcd_digit_fix.sv
// Combinational per-digit adjuster: double-dabble correction (mode 0) or excess-3 bias (mode 1).
// One instance per digit is shared by the SHIFT and BIAS states of the converter.
module bcd_digit_fix
    import xs3_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_mode,
    output logic [3:0] o_digit
);

    logic w_add;

    // A valid BCD digit never exceeds 9, so the 4-bit sum cannot wrap in either mode.
    assign w_add   = i_mode || (i_digit >= DABBLE_THRESH);
    assign o_digit = w_add ? (i_digit + XS3_BIAS) : i_digit;

endmodule

// File: rtl/binary_to_excess3_seq.sv
// Sequential unsigned-binary to packed excess-3 encoder using iterative shift-add-3.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module binary_to_excess3_seq
    import xs3_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   xs3_out,
    output logic                  busy,
    output state_t                dbg_state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W) + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SH_W-1:0]    r_shreg;
    logic [SH_W-1:0]    w_shreg_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BCD_W-1:0]   r_xs3;
    logic [BCD_W-1:0]   w_xs3_nxt;
    logic [BCD_W-1:0]   w_fixed;
    logic               w_mode;

    assign w_mode = (r_state == BIAS);

    // The BCD field sits above the binary field inside the shift register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_fix u_fix (
            .i_digit (r_shreg[BIN_W + 4*g +: 4]),
            .i_mode  (w_mode),
            .o_digit (w_fixed[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_xs3   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_xs3   <= w_xs3_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_xs3_nxt   = r_xs3;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_shreg_nxt = {{BCD_W{1'b0}}, bin_in};
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Correct digits first, then shift; the last shift gets no correction after it.
                w_shreg_nxt = {w_fixed, r_shreg[BIN_W-1:0]} << 1;
                w_cnt_nxt   = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_state_nxt = BIAS;
                end
            end
            BIAS: begin
                w_xs3_nxt   = w_fixed;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state == SHIFT) || (r_state == BIAS);
    assign xs3_out   = r_xs3;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_binary_to_excess3_seq.sv
// Directed bench for binary_to_excess3_seq: latency, backpressure, reset abort and a full 8-bit sweep.
module tb_binary_to_excess3_seq;
    import xs3_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  bin_in = 8'd0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [11:0] xs3_out;
    state_t      dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int bcnt;

    binary_to_excess3_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xs3_out   (xs3_out),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by division, each biased by 3.
    function automatic logic [11:0] golden(input int v);
        logic [3:0] d0, d1, d2;
        d0 = 4'(v % 10 + 3);
        d1 = 4'((v / 10) % 10 + 3);
        d2 = 4'((v / 100) % 10 + 3);
        return {d2, d1, d0};
    endfunction

    // Returns the decoded value, or -1 if any digit is not legal excess-3.
    function automatic int decode(input logic [11:0] x);
        int val;
        int scale;
        int d;
        val   = 0;
        scale = 1;
        for (int k = 0; k < 3; k++) begin
            d = int'(x[4*k +: 4]);
            if (d < 3 || d > 12) return -1;
            val   = val + (d - 3) * scale;
            scale = scale * 10;
        end
        return val;
    endfunction

    task automatic start(input logic [7:0] v);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("start_ready", 32'(in_ready), 32'd1);
        bin_in   = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the accepting edge.
    task automatic wait_out(output int c, output int b);
        c = 1;
        b = 0;
        while (!out_valid && c < 50) begin
            if (busy) b++;
            @(posedge clk); #1;
            c++;
        end
        check("out_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_xs3",       32'(xs3_out),   32'h000);
        check("rst_state",     32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero input, latency
        out_ready = 1'b1;
        start(8'd0);
        wait_out(cyc, bcnt);
        check("lat_zero", 32'(cyc), 32'd10);
        check("val_zero", 32'(xs3_out), 32'h333);
        check("zero_lead", 32'(xs3_out[11:8]), 32'(XS3_ZERO));
        @(posedge clk); #1;
        check("zero_done", 32'(out_valid), 32'd0);

        // Max input, busy duration
        start(8'd255);
        wait_out(cyc, bcnt);
        check("busy_255", 32'(bcnt), 32'd9);
        check("val_255", 32'(xs3_out), 32'h588);
        @(posedge clk); #1;

        // Back-to-back with out_ready high
        start(8'd9);
        wait_out(cyc, bcnt);
        check("val_9", 32'(xs3_out), 32'h33C);
        check("hold_not_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_hs", 32'(in_ready), 32'd1);
        start(8'd100);
        wait_out(cyc, bcnt);
        check("val_100", 32'(xs3_out), 32'h433);
        @(posedge clk); #1;

        // Backpressure with ignored in_valid pulses
        out_ready = 1'b0;
        start(8'd57);
        wait_out(cyc, bcnt);
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_xs3",   32'(xs3_out),   32'h38A);
            check("bp_ready", 32'(in_ready),  32'd0);
            if (i % 5 == 2) begin
                in_valid = 1'b1;
                bin_in   = 8'd200;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        // Handshake edge with in_valid also high: not accepted until IDLE
        in_valid  = 1'b1;
        bin_in    = 8'd200;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_out_valid", 32'(out_valid), 32'd0);
        check("hs_in_ready",  32'(in_ready),  32'd1);
        check("hs_not_busy",  32'(busy),      32'd0);
        check("hs_keep_xs3",  32'(xs3_out),   32'h38A);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("accept_next", 32'(busy), 32'd1);
        wait_out(cyc, bcnt);
        check("lat_200", 32'(cyc), 32'd10);
        check("val_200", 32'(xs3_out), 32'h533);
        @(posedge clk); #1;

        // Reset during SHIFT
        start(8'd77);
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_xs3",       32'(xs3_out),   32'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(out_valid), 32'd0);
        start(8'd128);
        wait_out(cyc, bcnt);
        check("val_128", 32'(xs3_out), 32'h45B);
        @(posedge clk); #1;

        // Full sweep
        for (int v = 0; v < 256; v++) begin
            start(8'(v));
            wait_out(cyc, bcnt);
            check("sweep_val", 32'(xs3_out), 32'(golden(v)));
            check("sweep_decode", 32'(decode(xs3_out)), 32'(v));
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
